// File: rtl/execute_muldiv_if.sv
// execute_muldiv_if: issue/result bundle between the execute stage and the
// iterative RV32M multiply/divide unit.
//   start   - ID/EX holds an M-type instruction
//   op      - funct3 (0 MUL .. 7 REMU)
//   op_a    - forwarded rs1 value
//   op_b    - forwarded rs2 value
//   rd_tag  - destination register of the issued instruction
//   flush   - branch-taken kill of the ID/EX instruction
//   stall   - freeze request to the hazard unit (combinational)
//   busy    - unit is iterating
//   done    - result/rd_done valid this cycle
//   result  - registered result
//   rd_done - destination tag belonging to result
interface execute_muldiv_if #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_WIDTH  = 5
);
  logic                  start;
  logic [2:0]            op;
  logic [DATA_WIDTH-1:0] op_a;
  logic [DATA_WIDTH-1:0] op_b;
  logic [REG_WIDTH-1:0]  rd_tag;
  logic                  flush;
  logic                  stall;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] result;
  logic [REG_WIDTH-1:0]  rd_done;

  modport master (
    output start, op, op_a, op_b, rd_tag, flush,
    input  stall, busy, done, result, rd_done
  );

  modport slave (
    input  start, op, op_a, op_b, rd_tag, flush,
    output stall, busy, done, result, rd_done
  );
endinterface

// File: rtl/execute_muldiv.sv
// execute_muldiv: iterative RV32M multiply/divide unit for the execute stage.
// Operands are converted to magnitudes at issue; UNROLL bits are retired per
// cycle (shift-add multiply / restoring divide on one 2*DATA_WIDTH register),
// and the sign correction is folded into the final iteration cycle. Divide by
// zero and signed overflow bypass iteration and complete the next cycle.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - execute_muldiv_if slave: start/op/op_a/op_b/rd_tag/flush in,
//          stall/busy/done/result/rd_done out
module execute_muldiv #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_WIDTH  = 5,
  parameter int UNROLL     = 1
) (
  input  logic                clk,
  input  logic                rst,
  execute_muldiv_if.slave     bus
);

  localparam int W  = DATA_WIDTH;
  localparam int N  = DATA_WIDTH / UNROLL;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state, state_next;

  logic [2:0]           op_q;
  logic                 neg_q;      // negate the final product / quotient / remainder
  logic [W-1:0]         opnd_q;     // multiplicand (mul) or divisor (div) magnitude
  logic [2*W-1:0]       acc_q;      // mul: {hi, multiplier/lo}; div: {rem, quotient}
  logic [CW-1:0]        cnt_q;
  logic [REG_WIDTH-1:0] tag_q;
  logic                 busy_q;
  logic                 done_q;
  logic [W-1:0]         result_q;
  logic [REG_WIDTH-1:0] rd_done_q;

  // Issue decode
  logic         is_div, sgn_a, sgn_b, a_neg, b_neg;
  logic         div_zero, div_ovf, special, issue;
  logic [W-1:0] mag_a, mag_b, special_res;

  always_comb begin
    is_div   = bus.op[2];
    sgn_a    = is_div ? ~bus.op[0] : (bus.op[1:0] != 2'b11);
    sgn_b    = is_div ? ~bus.op[0] : ~bus.op[1];
    a_neg    = sgn_a & bus.op_a[W-1];
    b_neg    = sgn_b & bus.op_b[W-1];
    mag_a    = a_neg ? W'(-bus.op_a) : bus.op_a;
    mag_b    = b_neg ? W'(-bus.op_b) : bus.op_b;
    div_zero = is_div & (bus.op_b == '0);
    div_ovf  = is_div & ~bus.op[0] & (bus.op_a == {1'b1, {(W-1){1'b0}}}) & (bus.op_b == '1);
    special  = div_zero | div_ovf;
    if (div_zero)
      special_res = bus.op[1] ? bus.op_a : '1;
    else
      special_res = bus.op[1] ? '0 : bus.op_a;
    issue    = (state == IDLE) & bus.start & ~bus.flush;
  end

  // One BUSY cycle of iteration plus the sign-corrected result it would yield
  logic [2*W-1:0] acc_it, prod_fix;
  logic [W:0]     sum, rem_sh, diff;
  logic [W-1:0]   quo_fix, rem_fix, final_res;

  always_comb begin
    acc_it = acc_q;
    sum    = '0;
    rem_sh = '0;
    diff   = '0;
    for (int unsigned i = 0; i < UNROLL; i++) begin
      if (!op_q[2]) begin
        // add multiplicand into the high half when the multiplier LSB is set, then shift right
        sum    = {1'b0, acc_it[2*W-1:W]} + (acc_it[0] ? {1'b0, opnd_q} : '0);
        acc_it = {sum, acc_it[W-1:1]};
      end else begin
        // shift next dividend bit into the remainder; keep the difference if no borrow
        rem_sh = {acc_it[2*W-1:W], acc_it[W-1]};
        diff   = rem_sh - {1'b0, opnd_q};
        if (!diff[W])
          acc_it = {diff[W-1:0], acc_it[W-2:0], 1'b1};
        else
          acc_it = {rem_sh[W-1:0], acc_it[W-2:0], 1'b0};
      end
    end
    prod_fix = neg_q ? -acc_it : acc_it;
    quo_fix  = neg_q ? -acc_it[W-1:0] : acc_it[W-1:0];
    rem_fix  = neg_q ? -acc_it[2*W-1:W] : acc_it[2*W-1:W];
    if (op_q == 3'd0)
      final_res = prod_fix[W-1:0];
    else if (!op_q[2])
      final_res = prod_fix[2*W-1:W];
    else if (op_q[1])
      final_res = rem_fix;
    else
      final_res = quo_fix;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (issue) state_next = special ? DONE : BUSY;
      BUSY: begin
        if (bus.flush)                  state_next = IDLE;
        else if (cnt_q == CW'(N - 1))   state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    bus.stall   = ((state == IDLE) & bus.start & ~bus.flush) | (state == BUSY);
    bus.busy    = busy_q;
    bus.done    = done_q;
    bus.result  = result_q;
    bus.rd_done = rd_done_q;
  end

  // Datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q      <= '0;
      neg_q     <= 1'b0;
      opnd_q    <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      tag_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      rd_done_q <= '0;
    end else begin
      busy_q <= (state_next == BUSY);
      done_q <= (state_next == DONE);
      case (state)
        IDLE: if (issue) begin
          op_q   <= bus.op;
          tag_q  <= bus.rd_tag;
          cnt_q  <= '0;
          neg_q  <= (is_div & bus.op[1]) ? a_neg : (a_neg ^ b_neg);
          opnd_q <= is_div ? mag_b : mag_a;
          acc_q  <= {{W{1'b0}}, (is_div ? mag_a : mag_b)};
          if (special) begin
            result_q  <= special_res;
            rd_done_q <= bus.rd_tag;
          end
        end
        BUSY: if (!bus.flush) begin
          acc_q <= acc_it;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(N - 1)) begin
            result_q  <= final_res;
            rd_done_q <= tag_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
